// File: rtl/cntr_updn_mod_pkg.sv
// Shared constants and types for the up/down modulo counter.
package cntr_updn_mod_pkg;

    // Bound behaviour selectors for the SATURATE parameter.
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Default counter width when the instantiating block does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Operation selected on a given edge, already resolved for priority.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_CLR   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_COUNT = 2'd3
    } op_e;

endpackage

// File: rtl/cntr_updn_mod_reg_n.sv
// WIDTH-bit register with write enable and asynchronous active-high reset to 0.
module reg_n #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on enabled edges; reset clears immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cntr_updn_mod.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate bounds,
// a one-cycle bound-event pulse and a sticky overflow flag.
module cntr_updn_mod
    import cntr_updn_mod_pkg::*;
#(
    parameter int     WIDTH    = DEFAULT_WIDTH,
    parameter longint MAX_VAL  = 255,
    parameter int     SATURATE = CNT_WRAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             evt,
    output logic             ovf
);

    // Bound in one extra bit so comparisons happen before truncation.
    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_VAL);
    localparam bit               SAT_MODE = (SATURATE == CNT_SAT);

    op_e              op;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             count_we;
    logic             evt_reg;
    logic             evt_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic [WIDTH:0]   load_ext;

    // Widened candidates: an increment past MAX_VAL or a borrow below 0
    // shows up in the extra bit instead of silently rolling over.
    assign inc_ext  = {1'b0, count_reg} + (WIDTH + 1)'(1);
    assign dec_ext  = {1'b0, count_reg} - (WIDTH + 1)'(1);
    assign load_ext = {1'b0, load_val};

    // Resolve control priority: clear beats load beats count enable.
    always_comb begin
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_COUNT;
        end
    end

    // Next count and flags for the selected operation.
    always_comb begin
        count_next = count_reg;
        evt_next   = 1'b0;
        ovf_next   = ovf_reg;
        case (op)
            OP_CLR: begin
                count_next = '0;
                ovf_next   = 1'b0;
            end
            OP_LOAD: begin
                count_next = (load_ext > MAX_EXT) ? MAX_CNT : load_val;
            end
            OP_COUNT: begin
                if (up) begin
                    if (inc_ext > MAX_EXT) begin
                        count_next = SAT_MODE ? MAX_CNT : '0;
                        evt_next   = 1'b1;
                        ovf_next   = 1'b1;
                    end else begin
                        count_next = inc_ext[WIDTH-1:0];
                    end
                end else begin
                    if (dec_ext[WIDTH]) begin
                        count_next = SAT_MODE ? '0 : MAX_CNT;
                        evt_next   = 1'b1;
                        ovf_next   = 1'b1;
                    end else begin
                        count_next = dec_ext[WIDTH-1:0];
                    end
                end
            end
            default: begin
                count_next = count_reg;
            end
        endcase
    end

    // Only touch the count register when an operation is actually selected.
    assign count_we = (op != OP_HOLD);

    reg_n #(
        .WIDTH (WIDTH)
    ) u_count_reg (
        .clock (clock),
        .reset (reset),
        .en    (count_we),
        .d     (count_next),
        .q     (count_reg)
    );

    // Event pulse and sticky overflow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            evt_reg <= evt_next;
            ovf_reg <= ovf_next;
        end
    end

    assign count = count_reg;
    assign evt   = evt_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_cntr_updn_mod.sv
// Directed bench for cntr_updn_mod: four configurations driven in sequence.
module tb_cntr_updn_mod;

    logic clock;
    logic reset;

    // A: WIDTH 8, MAX 255, wrap
    logic       a_clr, a_en, a_load, a_up, a_evt, a_ovf;
    logic [7:0] a_lv, a_cnt;
    // B: WIDTH 4, MAX 9, wrap
    logic       b_clr, b_en, b_load, b_up, b_evt, b_ovf;
    logic [3:0] b_lv, b_cnt;
    // C: WIDTH 4, MAX 9, saturate
    logic       c_clr, c_en, c_load, c_up, c_evt, c_ovf;
    logic [3:0] c_lv, c_cnt;
    // D: WIDTH 8, MAX 99, wrap
    logic       d_clr, d_en, d_load, d_up, d_evt, d_ovf;
    logic [7:0] d_lv, d_cnt;

    int total = 0;
    int bad   = 0;

    cntr_updn_mod #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0)) dut_a (
        .clock(clock), .reset(reset), .clr(a_clr), .en(a_en), .load(a_load),
        .load_val(a_lv), .up(a_up), .count(a_cnt), .evt(a_evt), .ovf(a_ovf));
    cntr_updn_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_b (
        .clock(clock), .reset(reset), .clr(b_clr), .en(b_en), .load(b_load),
        .load_val(b_lv), .up(b_up), .count(b_cnt), .evt(b_evt), .ovf(b_ovf));
    cntr_updn_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_c (
        .clock(clock), .reset(reset), .clr(c_clr), .en(c_en), .load(c_load),
        .load_val(c_lv), .up(c_up), .count(c_cnt), .evt(c_evt), .ovf(c_ovf));
    cntr_updn_mod #(.WIDTH(8), .MAX_VAL(99), .SATURATE(0)) dut_d (
        .clock(clock), .reset(reset), .clr(d_clr), .en(d_en), .load(d_load),
        .load_val(d_lv), .up(d_up), .count(d_cnt), .evt(d_evt), .ovf(d_ovf));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check count, evt and ovf of one instance in a single line of the sequence.
    task automatic chk3(input string tag, input logic [31:0] c, input logic e, input logic o,
                        input logic [31:0] xc, input logic xe, input logic xo);
        chk({tag, ".count"}, c, xc);
        chk({tag, ".evt"}, {31'd0, e}, {31'd0, xe});
        chk({tag, ".ovf"}, {31'd0, o}, {31'd0, xo});
        $display("step %-14s count=%0d evt=%0b ovf=%0b", tag, c, e, o);
    endtask

    initial begin
        reset = 1'b1;
        {a_clr, a_en, a_load, a_up} = '0; a_lv = '0;
        {b_clr, b_en, b_load, b_up} = '0; b_lv = '0;
        {c_clr, c_en, c_load, c_up} = '0; c_lv = '0;
        {d_clr, d_en, d_load, d_up} = '0; d_lv = '0;

        // Reset state
        step();
        chk3("rst_a", a_cnt, a_evt, a_ovf, 0, 0, 0);
        chk3("rst_b", b_cnt, b_evt, b_ovf, 0, 0, 0);
        chk3("rst_c", c_cnt, c_evt, c_ovf, 0, 0, 0);
        chk3("rst_d", d_cnt, d_evt, d_ovf, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;

        // A: full 8-bit wrap over 258 clocks
        a_en = 1'b1; a_up = 1'b1;
        for (int i = 1; i <= 258; i++) begin
            step();
            chk3($sformatf("a_up%0d", i), a_cnt, a_evt, a_ovf, i % 256, (i == 256), (i >= 256));
        end
        a_en = 1'b0;

        // B: modulus 10 counting up, never shows 10
        b_en = 1'b1; b_up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk3($sformatf("b_up%0d", i), b_cnt, b_evt, b_ovf, i % 10, (i == 10), (i >= 10));
        end

        // C: saturate at 9, repeated events while held, then count down
        c_load = 1'b1; c_lv = 4'd7;
        step(); chk3("c_load7", c_cnt, c_evt, c_ovf, 7, 0, 0);
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        step(); chk3("c_up1", c_cnt, c_evt, c_ovf, 8, 0, 0);
        step(); chk3("c_up2", c_cnt, c_evt, c_ovf, 9, 0, 0);
        step(); chk3("c_up3", c_cnt, c_evt, c_ovf, 9, 1, 1);
        step(); chk3("c_up4", c_cnt, c_evt, c_ovf, 9, 1, 1);
        step(); chk3("c_up5", c_cnt, c_evt, c_ovf, 9, 1, 1);
        c_up = 1'b0;
        step(); chk3("c_dn1", c_cnt, c_evt, c_ovf, 8, 0, 1);
        step(); chk3("c_dn2", c_cnt, c_evt, c_ovf, 7, 0, 1);
        c_en = 1'b0;
        step(); chk3("c_hold", c_cnt, c_evt, c_ovf, 7, 0, 1);

        // B: clear, underflow wrap, hold, clr priority, load keeps ovf
        b_en = 1'b0; b_clr = 1'b1;
        step(); chk3("b_clr", b_cnt, b_evt, b_ovf, 0, 0, 0);
        b_clr = 1'b0; b_en = 1'b1; b_up = 1'b0;
        step(); chk3("b_dn_wrap", b_cnt, b_evt, b_ovf, 9, 1, 1);
        b_en = 1'b0;
        step(); chk3("b_hold", b_cnt, b_evt, b_ovf, 9, 0, 1);
        b_clr = 1'b1; b_load = 1'b1; b_en = 1'b1; b_up = 1'b1; b_lv = 4'd5;
        step(); chk3("b_clr_wins", b_cnt, b_evt, b_ovf, 0, 0, 0);
        b_clr = 1'b0; b_load = 1'b0; b_up = 1'b0;
        step(); chk3("b_dn_wrap2", b_cnt, b_evt, b_ovf, 9, 1, 1);
        b_load = 1'b1; b_lv = 4'd3;
        step(); chk3("b_load_ovf", b_cnt, b_evt, b_ovf, 3, 0, 1);
        b_load = 1'b0; b_en = 1'b0;

        // D: load clamp, load beats en, then wrap at 99
        d_load = 1'b1; d_lv = 8'd200;
        step(); chk3("d_clamp", d_cnt, d_evt, d_ovf, 99, 0, 0);
        d_en = 1'b1; d_up = 1'b1; d_lv = 8'd5;
        step(); chk3("d_load_en", d_cnt, d_evt, d_ovf, 5, 0, 0);
        d_load = 1'b0;
        step(); chk3("d_inc", d_cnt, d_evt, d_ovf, 6, 0, 0);
        d_load = 1'b1; d_lv = 8'd98;
        step(); chk3("d_load98", d_cnt, d_evt, d_ovf, 98, 0, 0);
        d_load = 1'b0;
        step(); chk3("d_to99", d_cnt, d_evt, d_ovf, 99, 0, 0);
        step(); chk3("d_wrap", d_cnt, d_evt, d_ovf, 0, 1, 1);
        d_en = 1'b0;

        // A: asynchronous reset mid-count at 42
        a_load = 1'b1; a_lv = 8'd40;
        step(); chk3("a_load40", a_cnt, a_evt, a_ovf, 40, 0, 1);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
        step(); step();
        chk3("a_at42", a_cnt, a_evt, a_ovf, 42, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk3("a_async_rst", a_cnt, a_evt, a_ovf, 0, 0, 0);
        step(); chk3("a_rst_hold1", a_cnt, a_evt, a_ovf, 0, 0, 0);
        step(); chk3("a_rst_hold2", a_cnt, a_evt, a_ovf, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        step(); chk3("a_resume", a_cnt, a_evt, a_ovf, 1, 0, 0);
        step(); chk3("a_resume2", a_cnt, a_evt, a_ovf, 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
